// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access.
// One transaction in flight; data has priority, fetch starvation is bounded.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_wmask,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_memory_write
);

  typedef enum logic [2:0] {S_IDLE, S_REQ_IF, S_WAIT_IF, S_REQ_DM, S_WAIT_DM} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  state_t            r_state, w_next;
  logic [3:0]        r_streak;
  logic              r_drop;
  logic              r_mem_we;
  logic [3:0]        r_mem_wmask;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
  logic              r_if_valid, r_dm_valid;
  logic              w_pick_dm, w_pick_if;

  // Data wins unless fetch has already been passed over MAX_DM_STREAK times.
  assign w_pick_dm = dm_req & (~if_req | (r_streak < STREAK_MAX));
  assign w_pick_if = ~w_pick_dm & if_req & ~if_flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pick_dm) w_next = S_REQ_DM;
                 else if (w_pick_if) w_next = S_REQ_IF;
      S_REQ_IF:  if (mem_gnt) w_next = S_WAIT_IF;
                 else if (if_flush) w_next = S_IDLE;
      S_WAIT_IF: if (mem_rvalid) w_next = S_IDLE;
      S_REQ_DM:  if (mem_gnt) w_next = S_WAIT_DM;
      S_WAIT_DM: if (mem_rvalid) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_streak    <= '0;
      r_drop      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wmask <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      if (r_state == S_IDLE && w_pick_dm) begin
        r_mem_we    <= dm_we;
        r_mem_wmask <= dm_wmask;
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
      end else if (r_state == S_IDLE && w_pick_if) begin
        r_mem_we    <= 1'b0;
        r_mem_wmask <= '0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
      end
      if (r_state == S_REQ_DM && mem_gnt)
        r_streak <= !if_req ? 4'd0 : (r_streak == STREAK_MAX) ? r_streak : r_streak + 4'd1;
      if (r_state == S_REQ_IF && mem_gnt)
        r_streak <= '0;
      if (r_state == S_REQ_IF && mem_gnt && if_flush)
        r_drop <= 1'b1;
      // A flushed fetch still owns the port until its response drains.
      if (r_state == S_WAIT_IF) begin
        if (mem_rvalid) begin
          r_drop     <= 1'b0;
          r_if_rdata <= mem_rdata;
          r_if_valid <= ~r_drop & ~if_flush;
        end else if (if_flush) begin
          r_drop <= 1'b1;
        end
      end
      if (r_state == S_WAIT_DM && mem_rvalid) begin
        r_dm_rdata <= mem_rdata;
        r_dm_valid <= 1'b1;
      end
    end
  end

  assign mem_req            = (r_state == S_REQ_IF) | (r_state == S_REQ_DM);
  assign mem_we             = r_mem_we;
  assign mem_wmask          = r_mem_wmask;
  assign mem_addr           = r_mem_addr;
  assign mem_wdata          = r_mem_wdata;
  assign if_rdata           = r_if_rdata;
  assign if_valid           = r_if_valid;
  assign dm_rdata           = r_dm_rdata;
  assign dm_valid           = r_dm_valid;
  assign stall_fetch        = if_req & ~r_if_valid;
  assign stall_memory_write = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed handshake scenarios plus a randomized
// run against a word-level memory model and a fetch-starvation bound.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wmask;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, stall_fetch, stall_memory_write;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wmask(dm_wmask), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_memory_write(stall_memory_write)
  );

  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  bit [31:0] mem_m [bit [31:0]];  // what the memory bus actually wrote
  bit [31:0] ref_m [bit [31:0]];  // what the data requester intended

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : init_val(a);
  endfunction

  // ---------------- random-mode memory responder ----------------
  bit          auto_mem = 0;
  int          ph = 0, cnt = 0, pend_dgrants = 0;
  logic [31:0] s_addr, s_wdata, r_pend;
  logic        s_we;
  logic [3:0]  s_wmask;

  task automatic grant_now();
    mem_gnt = 1'b1;
    if (mem_addr >= 32'h2000) begin
      if (if_req) begin
        pend_dgrants++;
        checks++;
        if (pend_dgrants > MAXS) begin
          failures++;
          $display("FAIL rnd_starve data_grants_while_fetch_pending=%0d limit=%0d", pend_dgrants, MAXS);
        end
      end
      if (mem_we) begin
        mem_m[mem_addr] = merge(mem_rd(mem_addr), mem_wdata, mem_wmask);
        r_pend = $urandom;
      end else r_pend = mem_rd(mem_addr);
    end else begin
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL rnd_fetch_we got=%b want=0 addr=%h", mem_we, mem_addr);
      end
      r_pend = mem_rd(mem_addr);
    end
    ph = 2;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!auto_mem) begin
        ph = 0;
        continue;
      end
      case (ph)
        0: if (mem_req) begin
             s_addr = mem_addr; s_we = mem_we; s_wmask = mem_wmask; s_wdata = mem_wdata;
             cnt = $urandom_range(0, 2);
             if (cnt == 0) grant_now(); else ph = 1;
           end
        1: begin
             checks++;
             if ({mem_req, mem_we, mem_wmask, mem_addr, mem_wdata} !== {1'b1, s_we, s_wmask, s_addr, s_wdata}) begin
               failures++;
               $display("FAIL rnd_req_stable got=%b/%h want=1/%h", mem_req, mem_addr, s_addr);
             end
             cnt--;
             if (cnt == 0) grant_now();
           end
        2, 4: begin
             if (ph == 2) begin
               mem_gnt = 1'b0;
               checks++;
               if (mem_req !== 1'b0) begin
                 failures++;
                 $display("FAIL rnd_req_drop got=%b want=0", mem_req);
               end
               cnt = $urandom_range(0, 2);
               ph = 4;
             end else cnt--;
             if (cnt <= 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = r_pend;
               ph = 3;
             end
           end
        3: begin
             mem_rvalid = 1'b0;
             ph = 0;
           end
        default: ph = 0;
      endcase
    end
  end

  // ---------------- directed memory service ----------------
  task automatic serve(input int gdly, input int lat, input logic [31:0] rd,
                       output bit got, output logic [31:0] a, output logic we,
                       output logic [3:0] wm, output logic [31:0] wd,
                       output bit stable, output bit dropped);
    int t;
    t = 0; got = 0; stable = 1; dropped = 0; a = '0; we = 0; wm = '0; wd = '0;
    while (!mem_req && t < 10) begin @(negedge clk); t++; end
    if (!mem_req) return;
    got = 1; a = mem_addr; we = mem_we; wm = mem_wmask; wd = mem_wdata;
    repeat (gdly) begin
      @(negedge clk);
      if ({mem_req, mem_we, mem_wmask, mem_addr, mem_wdata} !== {1'b1, we, wm, a, wd}) stable = 0;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    dropped = (mem_req === 1'b0);
    repeat (lat - 1) @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_wmask, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem got=%b/%h want=0", mem_req, mem_addr);
    end
    checks++;
    if ({if_valid, dm_valid, stall_fetch, stall_memory_write, if_rdata, dm_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_out got=%b%b%b%b want=0000", if_valid, dm_valid, stall_fetch, stall_memory_write);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    dm_addr = 32'h44; dm_we = 0; dm_req = 1;
    for (int t = 0; t < 10 && !mem_req; t++) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
      failures++;
      $display("FAIL rstmid_req got=%b/%h want=1/00000044", mem_req, mem_addr);
    end
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    rst = 1; dm_req = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dm_valid !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_idle cyc=%0d got dm_valid=%b mem_req=%b want 0/0", k, dm_valid, mem_req);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_latency();
    if_addr = 32'h100; if_req = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, stall_fetch} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
      failures++;
      $display("FAIL fetch_issue got req=%b we=%b addr=%h stall=%b want 1/0/100/1", mem_req, mem_we, mem_addr, stall_fetch);
    end
    mem_gnt = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_gnt = 0;
      checks++;
      if ({mem_req, if_valid, stall_fetch} !== 3'b001) begin
        failures++;
        $display("FAIL fetch_wait cyc=%0d got req/valid/stall=%b%b%b want 001", k, mem_req, if_valid, stall_fetch);
      end
    end
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    @(negedge clk);
    mem_rvalid = 0;
    checks++;
    if ({if_valid, stall_fetch, if_rdata} !== {1'b1, 1'b0, 32'h00500093}) begin
      failures++;
      $display("FAIL fetch_resp got valid=%b stall=%b data=%h want 1/0/00500093", if_valid, stall_fetch, if_rdata);
    end
    if_req = 0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulse got=%b want=0", if_valid);
    end
  endtask

  task automatic test_priority();
    bit got, st, dr; logic [31:0] a, wd; logic we; logic [3:0] wm;
    dm_addr = 32'h2000; dm_we = 0; dm_req = 1;
    if_addr = 32'h300; if_req = 1;
    serve(0, 1, 32'h11112222, got, a, we, wm, wd, st, dr);
    checks++;
    if (!got || a !== 32'h2000 || we !== 1'b0) begin
      failures++;
      $display("FAIL prio_first got=%b addr=%h we=%b want 1/00002000/0", got, a, we);
    end
    checks++;
    if ({dm_valid, if_valid, dm_rdata} !== {1'b1, 1'b0, 32'h11112222}) begin
      failures++;
      $display("FAIL prio_load got dv=%b iv=%b data=%h want 1/0/11112222", dm_valid, if_valid, dm_rdata);
    end
    dm_req = 0;
    serve(0, 2, 32'h00000013, got, a, we, wm, wd, st, dr);
    checks++;
    if (!got || a !== 32'h300 || {if_valid, if_rdata} !== {1'b1, 32'h13}) begin
      failures++;
      $display("FAIL prio_fetch got=%b addr=%h valid=%b data=%h want 1/00000300/1/00000013", got, a, if_valid, if_rdata);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_streak();
    bit got, st, dr; logic [31:0] a, wd; logic we; logic [3:0] wm;
    bit exp_dm [6];
    exp_dm = '{1, 1, 1, 1, 0, 1};
    dm_addr = 32'h2000; dm_we = 0; dm_req = 1;
    if_addr = 32'h300; if_req = 1;
    for (int i = 0; i < 6; i++) begin
      serve(0, 1, 32'h0 + i, got, a, we, wm, wd, st, dr);
      checks++;
      if (!got || (a >= 32'h2000) !== exp_dm[i]) begin
        failures++;
        $display("FAIL streak_order grant=%0d got_data=%b want_data=%b addr=%h", i, a >= 32'h2000, exp_dm[i], a);
      end
      if (dm_valid) dm_addr = dm_addr + 4;
      if (if_valid) if_req = 0;
    end
    dm_req = 0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit got, st, dr; logic [31:0] a, wd; logic we; logic [3:0] wm;
    // flush while the fetch response is outstanding
    if_addr = 32'h180; if_req = 1;
    for (int t = 0; t < 10 && !mem_req; t++) @(negedge clk);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; if_flush = 1; if_addr = 32'h200;
    @(negedge clk);
    if_flush = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mem_req !== 1'b0) begin
        failures++;
        $display("FAIL flush_hold cyc=%0d got mem_req=%b want 0", k, mem_req);
      end
      if (k == 0) @(negedge clk);
    end
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 0;
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop got if_valid=%b want 0", if_valid);
    end
    serve(0, 1, 32'h00000013, got, a, we, wm, wd, st, dr);
    checks++;
    if (!got || a !== 32'h200 || {if_valid, if_rdata} !== {1'b1, 32'h13}) begin
      failures++;
      $display("FAIL flush_refetch got=%b addr=%h valid=%b data=%h want 1/00000200/1/00000013", got, a, if_valid, if_rdata);
    end
    if_req = 0;
    @(negedge clk);
    // flush before grant: request withdrawn
    if_addr = 32'h400; if_req = 1;
    for (int t = 0; t < 10 && !mem_req; t++) @(negedge clk);
    if_flush = 1; if_req = 0;
    @(negedge clk);
    if_flush = 0;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_req got mem_req=%b want 0", mem_req);
    end
    // flush coinciding with grant: response must be swallowed
    if_addr = 32'h480; if_req = 1;
    for (int t = 0; t < 10 && !mem_req; t++) @(negedge clk);
    mem_gnt = 1; if_flush = 1; if_req = 0;
    @(negedge clk);
    mem_gnt = 0; if_flush = 0;
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 0;
    checks++;
    if ({if_valid, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL flush_gnt got if_valid=%b mem_req=%b want 0/0", if_valid, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_store();
    bit got, st, dr; logic [31:0] a, wd; logic we; logic [3:0] wm;
    dm_addr = 32'h40; dm_we = 1; dm_wmask = 4'b0011; dm_wdata = 32'h1234; dm_req = 1;
    serve(2, 2, 32'hCAFE0000, got, a, we, wm, wd, st, dr);
    checks++;
    if (!got || {a, we, wm, wd} !== {32'h40, 1'b1, 4'b0011, 32'h1234}) begin
      failures++;
      $display("FAIL store_fields got addr=%h we=%b mask=%b data=%h want 00000040/1/0011/00001234", a, we, wm, wd);
    end
    checks++;
    if (st !== 1'b1 || dr !== 1'b1) begin
      failures++;
      $display("FAIL store_hold got stable=%b dropped=%b want 1/1", st, dr);
    end
    checks++;
    if ({dm_valid, stall_memory_write} !== 2'b10) begin
      failures++;
      $display("FAIL store_done got valid=%b stall=%b want 1/0", dm_valid, stall_memory_write);
    end
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    checks++;
    if (dm_valid !== 1'b0) begin
      failures++;
      $display("FAIL store_pulse got=%b want 0", dm_valid);
    end
  endtask

  task automatic fetch_driver(input int n);
    logic [31:0] a;
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      a = 32'h1000 + 4 * $urandom_range(0, 7);
      if_addr = a; if_req = 1; pend_dgrants = 0;
      t = 0;
      do begin @(negedge clk); t++; end while (!if_valid && t < 200);
      checks++;
      if (!if_valid) begin
        failures++;
        $display("FAIL rnd_fetch_timeout addr=%h", a);
        if_req = 0;
        return;
      end
      if (if_rdata !== init_val(a)) begin
        failures++;
        $display("FAIL rnd_fetch_data addr=%h got=%h want=%h", a, if_rdata, init_val(a));
      end
      if_req = 0;
    end
  endtask

  task automatic data_driver(input int n);
    logic [31:0] a, wd, ex;
    logic [3:0] m;
    logic w;
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      a = 32'h2000 + 4 * $urandom_range(0, 7);
      w = 1'($urandom_range(0, 1)); m = 4'($urandom_range(0, 15)); wd = $urandom;
      dm_addr = a; dm_we = w; dm_wmask = m; dm_wdata = wd; dm_req = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!dm_valid && t < 200);
      checks++;
      if (!dm_valid) begin
        failures++;
        $display("FAIL rnd_data_timeout addr=%h", a);
        dm_req = 0;
        return;
      end
      if (w) ref_m[a] = merge(ref_rd(a), wd, m);
      else begin
        ex = ref_rd(a);
        if (dm_rdata !== ex) begin
          failures++;
          $display("FAIL rnd_load addr=%h got=%h want=%h", a, dm_rdata, ex);
        end
      end
      dm_req = 0;
    end
  endtask

  task automatic test_random();
    mem_m.delete();
    ref_m.delete();
    auto_mem = 1;
    fork
      fetch_driver(30);
      data_driver(40);
    join
    repeat (3) @(negedge clk);
    auto_mem = 0;
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_wmask = '0; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_fetch_latency();
    test_priority();
    test_streak();
    test_flush();
    test_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch requester and the data (load/store) requester of the 3-stage pipeline.
- Sequences one outstanding memory transaction at a time using a request/grant/response-valid handshake.
- Gives data accesses priority, with bounded starvation for fetch.
- Generates the fetch and memory-write stage stalls consumed by the hazard logic, and discards in-flight fetch responses on a pipeline flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_STREAK, 4, consecutive data grants allowed while fetch is pending (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_valid or flush
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_flush  in  1  branch-taken flush; cancels the current fetch
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle fetch response pulse
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = store
- dm_wmask  in  4  store byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_wmask  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response/ack valid (one per granted request)
- mem_rdata  in  DATA_W  memory read data
- stall_fetch  out  1  fetch stage must hold
- stall_memory_write  out  1  memory-write stage must hold

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, streak=0, drop=0. All outputs 0 except stall outputs, which follow their formulas (0 when requests are low). A transaction in flight is abandoned; a later mem_rvalid while in IDLE is ignored.
- FSM states: IDLE, REQ_IF, WAIT_IF, REQ_DM, WAIT_DM.
- IDLE arbitration, evaluated each cycle:
  - dm_req and (not if_req or streak<MAX_DM_STREAK) -> REQ_DM.
  - else if_req and not if_flush -> REQ_IF.
  - else stay in IDLE.
- Request latching on entry to REQ_*: the selected requester's fields are latched into registers. mem_* outputs are driven from these registers, so mem_req and its fields are registered and stable until mem_gnt.
- REQ_*: mem_req=1.
  - mem_gnt -> WAIT_* and mem_req drops the next cycle.
  - Otherwise hold.
- WAIT_*: mem_req=0. On mem_rvalid:
  - Register mem_rdata into if_rdata/dm_rdata and pulse the matching valid for one cycle, one cycle after mem_rvalid.
  - Return to IDLE.
  - mem_rvalid in the same cycle as mem_gnt is illegal (minimum latency 1).
- Back-to-back: the earliest next mem_req is 2 cycles after the mem_rvalid cycle (valid pulse cycle + IDLE arbitration cycle).
- streak counter:
  - Increments on each data grant while if_req=1, saturating at MAX_DM_STREAK.
  - Clears on fetch grant, or when if_req=0 at a data grant.
- Flush:
  - In REQ_IF with if_flush and no mem_gnt: drop the request, mem_req=0 next cycle, go to IDLE.
  - In REQ_IF with if_flush and mem_gnt in the same cycle, or in WAIT_IF with if_flush: set drop=1. The response is consumed, if_valid is suppressed, and drop clears on that mem_rvalid.
  - Flush has no effect on data transactions.
  - The new (redirected) fetch cannot be issued until the dropped response returns.
- Stalls (combinational from registered state):
  - stall_fetch = if_req & ~if_valid.
  - stall_memory_write = dm_req & ~dm_valid.
- Stores: mem_rvalid completes the store; dm_rdata is don't-care but is still registered.

Test Plan:
- Reset mid-transaction: enter WAIT_DM, assert rst, then mem_rvalid after release -> no dm_valid; state IDLE; mem_req=0.
- Fetch-only, latency 3: if_req, if_addr=0x100, mem_gnt immediate, mem_rvalid 3 cycles later with rdata=0x00500093 -> if_valid single pulse with if_rdata=0x00500093; stall_fetch high until that cycle.
- Simultaneous if_req and dm_req (load 0x2000) -> data granted first; mem_addr=0x2000, mem_we=0; fetch follows after dm_valid.
- Continuous dm_req with if_req pending, MAX_DM_STREAK=4 -> 4 data grants, then 1 fetch grant, then streak resets and data resumes.
- Flush in WAIT_IF: mem_rvalid returns rdata=0xDEADBEEF -> no if_valid; the next fetch to 0x200 issues afterwards and completes normally.
- Store with wmask=4'b0011, addr=0x40, wdata=0x1234 -> mem_we=1, mem_wmask=0011, mem_wdata=0x1234 stable until mem_gnt (gnt delayed 2 cycles); dm_valid pulses once after mem_rvalid.
